sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//   Responder for the CPU's two SRAM-style master ports (inst_sram_*, data_sram_*).
//   Provides a shared word-addressed RAM (instruction port read-only, data port
//   read/byte-write), plus a small IO register window (LED, TIMER, SCRATCH) on the
//   data port. Sits directly below mycpu_top in the SoC-lite testbench top.
// PARAMETERS
//   MEM_LOG2   12             log2 of RAM depth in 32-bit words (4096 words = 16 KiB)
//   MEM_BASE   32'h0000_0000  RAM base; RAM hit when addr[31:MEM_LOG2+2] == MEM_BASE[31:MEM_LOG2+2]
//   IO_BASE    32'h1faf_0000  IO window base; IO hit when addr[31:8] == IO_BASE[31:8]
//   BAD_DATA   32'hDEAD_BEEF  read data returned for unmapped accesses
// PORTS
//   clk              in   1   clock, all state on rising edge
//   resetn           in   1   asynchronous active-low reset
//   inst_sram_en     in   1   instruction read request this cycle
//   inst_sram_addr   in   32  instruction byte address (word-aligned; addr[1:0] ignored)
//   inst_sram_rdata  out  32  instruction read data, valid cycle after request
//   inst_err         out  1   1-cycle pulse alongside rdata: request was unmapped or IO
//   data_sram_en     in   1   data request this cycle
//   data_sram_wen    in   4   byte write enables, bit i -> wdata[8i+7:8i]; 0 = read
//   data_sram_addr   in   32  data byte address (addr[1:0] ignored)
//   data_sram_wdata  in   32  write data
//   data_sram_rdata  out  32  data read data, valid cycle after request
//   data_err         out  1   1-cycle pulse alongside rdata/write: request was unmapped
//   led              out  16  LED register value
//   timer            out  32  TIMER register value
// BEHAVIOUR
//   Reset (resetn low, async): inst/data rdata=0, inst_err=data_err=0, led=0,
//     timer=0, scratch=0. RAM contents not reset. No write takes effect while low.
//   Latency: request in cycle T -> rdata/err valid in T+1 (registered). When en=0
//     in T, rdata holds previous value and err=0 in T+1.
//   Read with wen!=0 on data port: write performed; data_sram_rdata in T+1 = old
//     word contents (read-first), so store timing is uniform.
//   RAM writes: only bytes with wen[i]=1 change; other bytes keep value.
//   Inst port: read-only. RAM hit -> word; IO or unmapped -> BAD_DATA, inst_err=1.
//   Data port decode (priority RAM, then IO, else unmapped):
//     IO offset 0x00 LED: rw, bits[15:0]; reads return {16'b0, led}; wen[3:2] ignored.
//     IO offset 0x04 TIMER: rw, byte-merged write; increments by 1 every cycle,
//       wraps 32'hFFFF_FFFF -> 0. Write in T: timer(T+1) = merged wdata, increment
//       suppressed that cycle (write wins). Read in T returns value at T.
//     IO offset 0x08 SCRATCH: rw 32-bit, byte-merged.
//     Other IO offsets and unmapped: reads BAD_DATA, writes dropped, data_err=1.
//   Simultaneous same-word inst read and data write in T: inst rdata = old word;
//     inst read in T+1 returns new word.
//   Reset asserted mid-request: the pending response is discarded (outputs 0);
//     first response after release is for the first request after release.
// TESTING
//   1 reset: hold resetn=0 5 cycles -> all outputs 0; release, timer=1 after 1 edge.
//   2 data write addr 0x10 wdata 0x11223344 wen 4'b1111, then wen 4'b0010 wdata
//     0xAABBCCDD -> read 0x10 returns 0x1122CC44 in T+1; inst read 0x10 same.
//   3 same cycle: data write 0x20=0xCAFEF00D, inst read 0x20 (old 0) -> inst rdata 0;
//     next-cycle inst read -> 0xCAFEF00D.
//   4 write TIMER (0x1faf0004) = 0xFFFF_FFFE -> timer 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0.
//   5 data read 0x8000_0000 -> rdata 0xDEADBEEF, data_err=1 one cycle; inst read
//     0x1faf0000 -> 0xDEADBEEF, inst_err=1; LED write 0xFFFF_1234 -> led=16'h1234.
//   6 assert resetn low in cycle of data read of 0x10 -> rdata 0 after release,
//     RAM word 0x10 unchanged (still 0x1122CC44).

Source files
------------

// File: rtl/sram_responder.sv
// Word-addressed RAM behind the CPU's instruction and data SRAM ports.
// The data port also reaches a small IO window holding the LED, TIMER and SCRATCH registers.
module sram_responder #(
   parameter int unsigned MEM_LOG2 = 12,
   parameter logic [31:0] MEM_BASE = 32'h0000_0000,
   parameter logic [31:0] IO_BASE  = 32'h1faf_0000,
   parameter logic [31:0] BAD_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_rdata,
   output logic        inst_err,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        data_err,
   output logic [15:0] led,
   output logic [31:0] timer
);
   localparam int unsigned DEPTH       = 1 << MEM_LOG2;
   localparam logic [5:0]  OFF_LED     = 6'd0;
   localparam logic [5:0]  OFF_TIMER   = 6'd1;
   localparam logic [5:0]  OFF_SCRATCH = 6'd2;

   logic [31:0]         mem [DEPTH];
   logic [31:0]         scratch;
   logic [MEM_LOG2-1:0] inst_idx;
   logic [MEM_LOG2-1:0] data_idx;
   logic                inst_ram_hit;
   logic                data_ram_hit;
   logic                data_io_hit;
   logic [5:0]          data_off;
   logic                data_wr;
   logic                ram_we;
   logic                led_we;
   logic                timer_we;
   logic                scratch_we;
   logic                data_bad;
   logic [31:0]         data_rd_word;
   logic [15:0]         led_next;
   logic                unused_addr_bits;

   function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      end
      return r;
   endfunction

   assign inst_ram_hit = inst_sram_addr[31:MEM_LOG2+2] == MEM_BASE[31:MEM_LOG2+2];
   assign data_ram_hit = data_sram_addr[31:MEM_LOG2+2] == MEM_BASE[31:MEM_LOG2+2];
   assign data_io_hit  = data_sram_addr[31:8] == IO_BASE[31:8];
   assign inst_idx     = inst_sram_addr[MEM_LOG2+1:2];
   assign data_idx     = data_sram_addr[MEM_LOG2+1:2];
   assign data_off     = data_sram_addr[7:2];
   assign unused_addr_bits = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

   // RAM decode wins over IO if the two windows are ever configured to overlap
   assign data_wr    = data_sram_en && (data_sram_wen != 4'b0000);
   assign ram_we     = data_wr && data_ram_hit;
   assign led_we     = data_wr && !data_ram_hit && data_io_hit && (data_off == OFF_LED);
   assign timer_we   = data_wr && !data_ram_hit && data_io_hit && (data_off == OFF_TIMER);
   assign scratch_we = data_wr && !data_ram_hit && data_io_hit && (data_off == OFF_SCRATCH);

   assign led_next = {data_sram_wen[1] ? data_sram_wdata[15:8] : led[15:8],
                      data_sram_wen[0] ? data_sram_wdata[7:0]  : led[7:0]};

   always_comb begin
      data_rd_word = BAD_DATA;
      data_bad     = 1'b1;
      if (data_ram_hit) begin
         data_rd_word = mem[data_idx];
         data_bad     = 1'b0;
      end else if (data_io_hit) begin
         case (data_off)
            OFF_LED: begin
               data_rd_word = {16'h0000, led};
               data_bad     = 1'b0;
            end
            OFF_TIMER: begin
               data_rd_word = timer;
               data_bad     = 1'b0;
            end
            OFF_SCRATCH: begin
               data_rd_word = scratch;
               data_bad     = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Contents are not reset, but a write must not land while reset is held
   always_ff @(posedge clk or negedge resetn) begin
      if (resetn && ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inst_sram_rdata <= 32'h0;
         inst_err        <= 1'b0;
         data_sram_rdata <= 32'h0;
         data_err        <= 1'b0;
         led             <= 16'h0;
         timer           <= 32'h0;
         scratch         <= 32'h0;
      end else begin
         inst_err <= 1'b0;
         if (inst_sram_en) begin
            if (inst_ram_hit) begin
               inst_sram_rdata <= mem[inst_idx];
            end else begin
               inst_sram_rdata <= BAD_DATA;
               inst_err        <= 1'b1;
            end
         end
         data_err <= 1'b0;
         if (data_sram_en) begin
            data_sram_rdata <= data_rd_word;
            data_err        <= data_bad;
         end
         if (led_we) led <= led_next;
         timer <= timer_we ? byte_merge(timer, data_sram_wdata, data_sram_wen) : timer + 32'd1;
         if (scratch_we) scratch <= byte_merge(scratch, data_sram_wdata, data_sram_wen);
      end
   end
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: a hand-derived vector table, directed corner sequences,
// and random traffic scored against an address-map reference model.
module tb_sram_responder;
   localparam logic [31:0] BAD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        inst_err;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        data_err;
   logic [15:0] led;
   logic [31:0] timer;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sram_responder dut (
      .clk             (clk),
      .resetn          (resetn),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .inst_err        (inst_err),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .data_err        (data_err),
      .led             (led),
      .timer           (timer)
   );

   // Reference model: RAM words by word index, IO registers, expected port outputs
   logic [31:0] m_mem [int unsigned];
   logic [15:0] m_led;
   logic [31:0] m_timer;
   logic [31:0] m_scratch;
   logic [31:0] exp_irdata;
   logic [31:0] exp_drdata;
   logic        exp_ierr;
   logic        exp_derr;
   logic        exp_i_known;
   logic        exp_d_known;

   typedef struct {
      logic        ie;
      logic [31:0] ia;
      logic        de;
      logic [3:0]  wen;
      logic [31:0] da;
      logic [31:0] wd;
      logic        ci;
      logic [31:0] ei;
      logic        eie;
      logic        cd;
      logic [31:0] ed;
      logic        ede;
   } vec_t;

   vec_t vecs[14];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      end
      return r;
   endfunction

   task automatic model_reset();
      m_led       = 16'h0;
      m_timer     = 32'h0;
      m_scratch   = 32'h0;
      exp_irdata  = 32'h0;
      exp_drdata  = 32'h0;
      exp_ierr    = 1'b0;
      exp_derr    = 1'b0;
      exp_i_known = 1'b1;
      exp_d_known = 1'b1;
   endtask

   // One clock of traffic: drive, predict from the pre-edge model state, clock, compare.
   task automatic do_cycle(input logic ie, input logic [31:0] ia, input logic de,
                           input logic [3:0] dwen, input logic [31:0] da, input logic [31:0] dwd);
      logic [31:0] nt;
      logic [31:0] old;
      int unsigned w;
      inst_sram_en    = ie;
      inst_sram_addr  = ia;
      data_sram_en    = de;
      data_sram_wen   = dwen;
      data_sram_addr  = da;
      data_sram_wdata = dwd;
      exp_ierr = 1'b0;
      exp_derr = 1'b0;
      nt = m_timer + 32'd1;
      if (ie) begin
         if ((ia >> 14) == 0) begin
            w = ia >> 2;
            exp_i_known = m_mem.exists(w);
            if (exp_i_known) exp_irdata = m_mem[w];
         end else begin
            exp_i_known = 1'b1;
            exp_irdata  = BAD;
            exp_ierr    = 1'b1;
         end
      end
      if (de) begin
         if ((da >> 14) == 0) begin
            w = da >> 2;
            exp_d_known = m_mem.exists(w);
            old = exp_d_known ? m_mem[w] : 32'h0;
            if (exp_d_known) exp_drdata = old;
            if (dwen != 4'h0 && (exp_d_known || dwen == 4'hF)) m_mem[w] = merge(old, dwd, dwen);
         end else if ((da >> 8) == 32'h001F_AF00) begin
            exp_d_known = 1'b1;
            case (da[7:2])
               6'd0: begin
                  exp_drdata = {16'h0, m_led};
                  if (dwen != 4'h0) begin
                     old   = merge({16'h0, m_led}, dwd, dwen & 4'b0011);
                     m_led = old[15:0];
                  end
               end
               6'd1: begin
                  exp_drdata = m_timer;
                  if (dwen != 4'h0) nt = merge(m_timer, dwd, dwen);
               end
               6'd2: begin
                  exp_drdata = m_scratch;
                  if (dwen != 4'h0) m_scratch = merge(m_scratch, dwd, dwen);
               end
               default: begin
                  exp_drdata = BAD;
                  exp_derr   = 1'b1;
               end
            endcase
         end else begin
            exp_d_known = 1'b1;
            exp_drdata  = BAD;
            exp_derr    = 1'b1;
         end
      end
      m_timer = nt;
      @(posedge clk);
      #1;
      if (exp_i_known) check32("inst_rdata", inst_sram_rdata, exp_irdata);
      check32("inst_err", {31'h0, inst_err}, {31'h0, exp_ierr});
      if (exp_d_known) check32("data_rdata", data_sram_rdata, exp_drdata);
      check32("data_err", {31'h0, data_err}, {31'h0, exp_derr});
      check32("led", {16'h0, led}, {16'h0, m_led});
      check32("timer", timer, m_timer);
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: a = 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         6:       a = 32'h1faf_0000 | (32'($urandom_range(0, 2)) << 2);
         7:       a = 32'h1faf_0000 | 32'($urandom_range(0, 255));
         8:       a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
         default: a = 32'h1faf_0004;
      endcase
      return a;
   endfunction

   initial begin
      vecs[0]  = '{1'b0, 32'h0, 1'b1, 4'hF, 32'h10, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 32'h0, 1'b1, 4'b0010, 32'h10, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1122_3344, 1'b0};
      vecs[2]  = '{1'b1, 32'h10, 1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 32'h1122_CC44, 1'b0, 1'b1, 32'h1122_CC44, 1'b0};
      vecs[3]  = '{1'b1, 32'h1faf_0000, 1'b1, 4'h0, 32'h8000_0000, 32'h0, 1'b1, BAD, 1'b1, 1'b1, BAD, 1'b1};
      vecs[4]  = '{1'b0, 32'h0, 1'b1, 4'hF, 32'h1faf_0000, 32'hFFFF_1234, 1'b1, BAD, 1'b0, 1'b1, 32'h0, 1'b0};
      vecs[5]  = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h1faf_0000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1234, 1'b0};
      vecs[6]  = '{1'b0, 32'h0, 1'b1, 4'hF, 32'h1faf_0008, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
      vecs[7]  = '{1'b0, 32'h0, 1'b1, 4'b1000, 32'h1faf_0008, 32'h3C00_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0};
      vecs[8]  = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h1faf_0008, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3CA5_A5A5, 1'b0};
      vecs[9]  = '{1'b0, 32'h0, 1'b1, 4'hF, 32'h1faf_000C, 32'h1, 1'b0, 32'h0, 1'b0, 1'b1, BAD, 1'b1};
      vecs[10] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, BAD, 1'b0};
      vecs[11] = '{1'b0, 32'h0, 1'b1, 4'b1100, 32'h1faf_0000, 32'h5678_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1234, 1'b0};
      vecs[12] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h1faf_0000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1234, 1'b0};
      vecs[13] = '{1'b1, 32'h4000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, BAD, 1'b1, 1'b1, 32'h0000_1234, 1'b0};

      resetn          = 1'b0;
      inst_sram_en    = 1'b0;
      inst_sram_addr  = 32'h0;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      model_reset();

      repeat (5) @(posedge clk);
      #1;
      check32("rst_inst_rdata", inst_sram_rdata, 32'h0);
      check32("rst_inst_err", {31'h0, inst_err}, 32'h0);
      check32("rst_data_rdata", data_sram_rdata, 32'h0);
      check32("rst_data_err", {31'h0, data_err}, 32'h0);
      check32("rst_led", {16'h0, led}, 32'h0);
      check32("rst_timer", timer, 32'h0);
      resetn = 1'b1;
      do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      check32("timer_after_release", timer, 32'd1);

      for (int i = 0; i < 14; i++) begin
         do_cycle(vecs[i].ie, vecs[i].ia, vecs[i].de, vecs[i].wen, vecs[i].da, vecs[i].wd);
         if (vecs[i].ci) check32($sformatf("vec%0d_inst_rdata", i), inst_sram_rdata, vecs[i].ei);
         check32($sformatf("vec%0d_inst_err", i), {31'h0, inst_err}, {31'h0, vecs[i].eie});
         if (vecs[i].cd) check32($sformatf("vec%0d_data_rdata", i), data_sram_rdata, vecs[i].ed);
         check32($sformatf("vec%0d_data_err", i), {31'h0, data_err}, {31'h0, vecs[i].ede});
      end

      // Same-word collision: the instruction port sees the word as it was before the store
      do_cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h20, 32'h0);
      do_cycle(1'b1, 32'h20, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D);
      check32("collide_inst_old", inst_sram_rdata, 32'h0);
      do_cycle(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0);
      check32("collide_inst_new", inst_sram_rdata, 32'hCAFE_F00D);

      // Timer write wins over increment, then wraps through zero
      do_cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h1faf_0004, 32'hFFFF_FFFE);
      check32("timer_wr", timer, 32'hFFFF_FFFE);
      do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      check32("timer_max", timer, 32'hFFFF_FFFF);
      do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      check32("timer_wrap", timer, 32'h0);
      do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h1faf_0004, 32'h0);
      check32("timer_read", data_sram_rdata, 32'h0);

      for (int i = 0; i < 16; i++) begin
         do_cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h100 + 32'(i) * 4, $urandom);
      end
      for (int i = 0; i < 400; i++) begin
         do_cycle(1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                  pick_addr(), $urandom);
      end

      // Reset lands on a pending read; a store held during reset must not reach RAM
      inst_sram_en   = 1'b0;
      data_sram_en   = 1'b1;
      data_sram_wen  = 4'h0;
      data_sram_addr = 32'h10;
      #2 resetn = 1'b0;
      #1;
      check32("rst_mid_data_rdata", data_sram_rdata, 32'h0);
      check32("rst_mid_timer", timer, 32'h0);
      data_sram_wen   = 4'hF;
      data_sram_wdata = 32'h0;
      @(posedge clk);
      #1;
      check32("rst_held_data_rdata", data_sram_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      model_reset();
      do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      check32("rst_release_rdata", data_sram_rdata, 32'h0);
      do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
      check32("rst_ram_kept", data_sram_rdata, 32'h1122_CC44);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
